// File: rtl/midi_note_decoder.sv
// MIDI note decoder: parses a UART byte stream with running status and
// emits one-cycle note-on / note-off pulses with key, velocity and channel.
// Optional build macro MIDI_CH_FILTER_EN restricts events to channel MIDI_CH;
// without it every channel produces events (omni).
module midi_note_decoder #(
   parameter logic [3:0] MIDI_CH = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   output logic       note_on,
   output logic       note_off,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA1 = 2'd1;
   localparam logic [1:0] S_DATA2 = 2'd2;

   logic [1:0] r_state;
   logic [7:0] r_status;
   logic [6:0] r_key;
   logic       r_note_on;
   logic       r_note_off;
   logic [6:0] r_note;
   logic [6:0] r_vel;
   logic [3:0] r_chan;

   logic       w_is_rt;
   logic       w_is_sys;
   logic       w_is_stat;
   logic       w_is_data;
   logic [3:0] w_type;
   logic       w_one_byte;
   logic       w_ch_ok;
   logic       w_done2;
   logic       w_vel_zero;
   logic       w_ev_on;
   logic       w_ev_off;

   assign w_is_rt    = (rx_data[7:3] == 5'b11111);
   assign w_is_sys   = (rx_data[7:3] == 5'b11110);
   assign w_is_stat  = rx_data[7] && (rx_data[7:4] != 4'hF);
   assign w_is_data  = !rx_data[7];
   assign w_type     = r_status[7:4];
   assign w_one_byte = (w_type == 4'hC) || (w_type == 4'hD);

`ifdef MIDI_CH_FILTER_EN
   assign w_ch_ok = (r_status[3:0] == MIDI_CH);
`else
   // omni: every channel is accepted regardless of MIDI_CH
   assign w_ch_ok = (r_status[3:0] == MIDI_CH) || 1'b1;
`endif

   // Second data byte arriving completes a two-byte message.
   assign w_done2    = rx_rdy && w_is_data && (r_state == S_DATA2);
   assign w_vel_zero = (rx_data[6:0] == 7'd0);
   assign w_ev_on    = w_done2 && w_ch_ok && (w_type == 4'h9) && !w_vel_zero;
   assign w_ev_off   = w_done2 && w_ch_ok &&
                       ((w_type == 4'h8) || ((w_type == 4'h9) && w_vel_zero));

   // Byte parser: state, running status and first data byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_status <= 8'h00;
         r_key    <= 7'd0;
      end else if (rx_rdy && !w_is_rt) begin
         if (w_is_sys) begin
            r_status <= 8'h00;
            r_state  <= S_IDLE;
         end else if (w_is_stat) begin
            r_status <= rx_data;
            r_state  <= S_DATA1;
         end else if (w_is_data) begin
            case (r_state)
               S_DATA1: begin
                  if (!w_one_byte) begin
                     r_key   <= rx_data[6:0];
                     r_state <= S_DATA2;
                  end
               end
               S_DATA2: r_state <= S_DATA1;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Event outputs: pulses last one cycle, fields hold until the next event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_note_on  <= 1'b0;
         r_note_off <= 1'b0;
         r_note     <= 7'd0;
         r_vel      <= 7'd0;
         r_chan     <= 4'd0;
      end else begin
         r_note_on  <= w_ev_on;
         r_note_off <= w_ev_off;
         if (w_ev_on || w_ev_off) begin
            r_note <= r_key;
            r_vel  <= rx_data[6:0];
            r_chan <= r_status[3:0];
         end
      end
   end

   assign note_on  = r_note_on;
   assign note_off = r_note_off;
   assign note     = r_note;
   assign velocity = r_vel;
   assign channel  = r_chan;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Scoreboard bench for midi_note_decoder: expected events are queued when the
// completing byte is driven and compared when the DUT pulses.
module tb_midi_note_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdy = 1'b0;
   logic       note_on;
   logic       note_off;
   logic [6:0] note;
   logic [6:0] velocity;
   logic [3:0] channel;

   typedef struct {
      int         cyc;
      bit         on;
      bit         off;
      logic [6:0] nt;
      logic [6:0] vel;
      logic [3:0] ch;
   } ev_t;

   ev_t q[$];
   int  pcnt = 0;
   int  n_checks = 0;
   int  n_errors = 0;

   midi_note_decoder #(.MIDI_CH(4'd0)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_rdy   (rx_rdy),
      .note_on  (note_on),
      .note_off (note_off),
      .note     (note),
      .velocity (velocity),
      .channel  (channel)
   );

   always #5 clk = ~clk;

   always @(posedge clk) pcnt <= pcnt + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, pcnt);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
   endtask

   // Byte that completes a note message; the event is expected one cycle later.
   task automatic send_ev(input logic [7:0] b, input bit on, input bit off,
                          input logic [6:0] nt, input logic [3:0] ch);
      ev_t e;
      @(negedge clk);
`ifdef MIDI_CH_FILTER_EN
      if (ch == 4'd0) begin
`else
      begin
`endif
         e.cyc = pcnt + 1;
         e.on  = on;
         e.off = off;
         e.nt  = nt;
         e.vel = b[6:0];
         e.ch  = ch;
         q.push_back(e);
      end
      rx_data = b;
      rx_rdy  = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_rdy  = 1'b0;
         rx_data = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic check_outs(input string tag, input logic [6:0] nt,
                             input logic [6:0] vel, input logic [3:0] ch);
      chk({tag, "_note"}, int'(note), int'(nt));
      chk({tag, "_vel"}, int'(velocity), int'(vel));
      chk({tag, "_chan"}, int'(channel), int'(ch));
   endtask

   task automatic drain(input string tag);
      idle(3);
      chk({tag, "_missing"}, q.size(), 0);
      q.delete();
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && (note_on || note_off)) begin
         chk("exclusive", int'(note_on & note_off), 0);
         if (q.size() == 0) begin
            chk("spurious_pulse", 1, 0);
         end else begin
            ev_t e;
            e = q.pop_front();
            chk("ev_cycle", pcnt, e.cyc);
            chk("ev_on", int'(note_on), int'(e.on));
            chk("ev_off", int'(note_off), int'(e.off));
            chk("ev_note", int'(note), int'(e.nt));
            chk("ev_vel", int'(velocity), int'(e.vel));
            chk("ev_chan", int'(channel), int'(e.ch));
         end
      end
   end

   initial begin
      // Reset state
      idle(3);
      chk("rst_on", int'(note_on), 0);
      chk("rst_off", int'(note_off), 0);
      check_outs("rst", 7'd0, 7'd0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Basic note-on
      send(8'h90); send(8'h3C); send_ev(8'h64, 1, 0, 7'h3C, 4'd0);
      drain("t31");
      check_outs("t31_hold", 7'h3C, 7'h64, 4'd0);

      // Running status: note-on, then velocity-0 note-on acts as note-off
      send(8'h90); send(8'h3C); send_ev(8'h64, 1, 0, 7'h3C, 4'd0);
      send(8'h40); send_ev(8'h00, 0, 1, 7'h40, 4'd0);
      send(8'h3E); send_ev(8'h50, 1, 0, 7'h3E, 4'd0);
      drain("t32");

      // Real-time bytes interleaved
      send(8'h80); send(8'hF8); send(8'h3C); send(8'hF8);
      send_ev(8'h7F, 0, 1, 7'h3C, 4'd0);
      idle(2);
      send(8'hFE);
      drain("t33");
      check_outs("t33_hold", 7'h3C, 7'h7F, 4'd0);

      // Non-note messages: parsed but silent, outputs held
      send(8'hA0); send(8'h3C); send(8'h40);
      send(8'hB0); send(8'h07); send(8'h64); send(8'h08); send(8'h10);
      send(8'hE0); send(8'h00); send(8'h40);
      send(8'hD0); send(8'h20); send(8'h30);
      send(8'hC3); send(8'h05);
      drain("t25");
      check_outs("t25_hold", 7'h3C, 7'h7F, 4'd0);

      // Aborted message, program change, then note-on on channel 1
      send(8'h90); send(8'h3C); send(8'hC0); send(8'h05);
      send(8'h91); send(8'h20); send_ev(8'h10, 1, 0, 7'h20, 4'd1);
      drain("t34");

      // Other channel, note-off with running status
      send(8'h85); send(8'h11); send_ev(8'h22, 0, 1, 7'h11, 4'd5);
      send(8'h12); send_ev(8'h00, 0, 1, 7'h12, 4'd5);
      drain("t30");

      // System common clears running status
      send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7);
      send(8'h3C); send(8'h64);
      drain("t36");
      chk("t36_state_idle", int'(dut.r_state), 0);

      // Reset mid-message
      send(8'h90); send(8'h3C);
      @(negedge clk);
      rx_rdy = 1'b0;
      rst = 1'b0;
      idle(1);
      check_outs("t35_in_rst", 7'd0, 7'd0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      send(8'h64);
      drain("t35");
      chk("t35_on", int'(note_on), 0);
      chk("t35_off", int'(note_off), 0);
      check_outs("t35_after", 7'd0, 7'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
